aes_subshift_seq: RTL and testbench

- Byte-serial SubBytes + ShiftRows datapath for one AES-128 round.
- Driven by the round controller; sequences 16 byte substitutions through a shared external combinational S-box, then applies ShiftRows in one cycle.
- Delivers the 128-bit result to MixColumns with a one-cycle done pulse.
- The byte index it walks is exported so the round controller and debug logic can track progress.

---
 rtl/aes_subshift_seq.sv | 107 ++++++++++
 tb/tb_aes_subshift_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subshift_seq.sv
// aes_subshift_seq: byte-serial SubBytes followed by a one-cycle ShiftRows
// (or InvShiftRows when INV=1) for one AES-128 round. The S-box sits
// outside this block and is combinational: sbox_addr -> sbox_data.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; state_out holds the last completed result
// SUB   | 16 cycles, one byte per cycle replaced by its S-box value
// SHIFT | one cycle, row rotation into state_out and done pulse
module aes_subshift_seq #(
    parameter bit INV = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic [7:0]   sbox_addr,
    input  logic [7:0]   sbox_data,
    output logic [3:0]   byte_idx,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out
);

    typedef enum logic [1:0] {IDLE, SUB, SHIFT} state_t;

    state_t         fsm_q;
    logic [3:0]     idx_q;
    logic [127:0]   st_q;
    logic [127:0]   st_d;
    logic [127:0]   out_q;
    logic [127:0]   out_d;
    logic           done_q;
    logic [6:0]     bit_base;

    // Byte i lives at bits [127-8i -: 8]; for a 4-bit index 15-i is ~i.
    assign bit_base = {~idx_q, 3'b000};

    // Row r rotated left by r (forward) or right by r (inverse), column-major bytes.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (INV)
                    src = r + 4 * ((c - r + 4) % 4);
                else
                    src = r + 4 * ((c + r) % 4);
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * src -: 8];
            end
        end
        return o;
    endfunction

    // Next internal state with the current byte replaced, and the shifted result.
    always_comb begin
        st_d = st_q;
        st_d[bit_base +: 8] = sbox_data;
        out_d = shift_rows(st_q);
    end

    // Main sequencer: load, 16 substitutions, shift with done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= IDLE;
            idx_q  <= 4'd0;
            st_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        st_q  <= state_in;
                        idx_q <= 4'd0;
                        fsm_q <= SUB;
                    end
                end
                SUB: begin
                    st_q  <= st_d;
                    idx_q <= idx_q + 4'd1;
                    if (idx_q == 4'd15)
                        fsm_q <= SHIFT;
                end
                SHIFT: begin
                    out_q  <= out_d;
                    done_q <= 1'b1;
                    fsm_q  <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    // Outside SUB the S-box still sees byte 0 so the address never floats.
    always_comb begin
        sbox_addr = (fsm_q == SUB) ? st_q[bit_base +: 8] : st_q[127:120];
        byte_idx  = (fsm_q == SUB) ? idx_q : 4'd0;
        busy      = (fsm_q != IDLE);
    end

    assign done      = done_q;
    assign state_out = out_q;

endmodule

// File: tb/tb_aes_subshift_seq.sv
// Bench for aes_subshift_seq: one forward instance with the real AES S-box
// and one inverse instance with an identity S-box, driven in lockstep.
module tb_aes_subshift_seq;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] V1   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V1_F = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    // InvShiftRows undoes the forward shift, giving back round-1 SubBytes output.
    localparam logic [127:0] V3_I = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V4   = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] state_in;
    logic [7:0]   addr0, addr1, data0, data1;
    logic [3:0]   idx0, idx1;
    logic         busy0, busy1, done0, done1;
    logic [127:0] out0, out1;

    int checks = 0;
    int errors = 0;
    int ndone0 = 0;
    int ndone1 = 0;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    assign data0 = sb(addr0);
    assign data1 = addr1;

    aes_subshift_seq #(.INV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .sbox_addr(addr0), .sbox_data(data0), .byte_idx(idx0),
        .busy(busy0), .done(done0), .state_out(out0));

    aes_subshift_seq #(.INV(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .sbox_addr(addr1), .sbox_data(data1), .byte_idx(idx1),
        .busy(busy1), .done(done1), .state_out(out1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Rows taken as 32-bit words and rotated as a whole.
    function automatic logic [127:0] shift_model(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [31:0]  row, rot;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++)
                row[31 - 8 * c -: 8] = s[127 - 8 * (r + 4 * c) -: 8];
            if (r == 0)
                rot = row;
            else if (inv)
                rot = (row >> (8 * r)) | (row << (32 - 8 * r));
            else
                rot = (row << (8 * r)) | (row >> (32 - 8 * r));
            for (int c = 0; c < 4; c++)
                o[127 - 8 * (r + 4 * c) -: 8] = rot[31 - 8 * c -: 8];
        end
        return o;
    endfunction

    // Behavioural model: phase 0 idle, 1..16 substituting byte phase-1, 17 shifting.
    int           phase = 0;
    bit           mv = 1'b0;
    logic [127:0] cur0 = '0, cur1 = '0, exp0 = '0, exp1 = '0;
    logic         exp_done = 1'b0;

    always @(posedge clk) begin
        mv = 1'b1;
        if (rst) begin
            phase = 0; cur0 = '0; cur1 = '0; exp0 = '0; exp1 = '0; exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (phase == 0) begin
                if (start) begin
                    cur0 = state_in; cur1 = state_in; phase = 1;
                end
            end else if (phase <= 16) begin
                cur0[127 - 8 * (phase - 1) -: 8] = sb(cur0[127 - 8 * (phase - 1) -: 8]);
                phase++;
            end else begin
                exp0 = shift_model(cur0, 1'b0);
                exp1 = shift_model(cur1, 1'b1);
                exp_done = 1'b1;
                phase = 0;
            end
        end
    end

    // Every cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (mv) begin
            int  j;
            bit  sub;
            sub = (phase >= 1 && phase <= 16);
            j   = sub ? phase - 1 : 0;
            chk("busy0", 128'(busy0), 128'(phase != 0));
            chk("busy1", 128'(busy1), 128'(phase != 0));
            chk("done0", 128'(done0), 128'(exp_done));
            chk("done1", 128'(done1), 128'(exp_done));
            chk("byte_idx0", 128'(idx0), 128'(j));
            chk("byte_idx1", 128'(idx1), 128'(j));
            chk("sbox_addr0", 128'(addr0), 128'(cur0[127 - 8 * j -: 8]));
            chk("sbox_addr1", 128'(addr1), 128'(cur1[127 - 8 * j -: 8]));
            chk("state_out0", out0, exp0);
            chk("state_out1", out1, exp1);
            if (done0) ndone0++;
            if (done1) ndone1++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one pass; optional extra start pokes at loop steps p1/p2 and
    // scrambled state_in while busy. Returns clocks to done and busy cycles.
    task automatic run_pass(input logic [127:0] s, input int p1, input int p2,
                            input bit scramble, output int lat, output int nbusy);
        state_in = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        nbusy = busy0 ? 1 : 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == p1 || n == p2) start = 1'b1;
            if (scramble) state_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            start = 1'b0;
            if (busy0) nbusy++;
            if (done0) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat, nb;

    initial begin
        rst = 1'b1; start = 1'b0; state_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_busy", 128'(busy0), 128'(0));
        chk("reset_done", 128'(done0), 128'(0));
        chk("reset_out", out0, 128'(0));
        chk("reset_idx", 128'(idx0), 128'(0));
        tick();

        // FIPS-197 round 1 forward
        state_in = V1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_addr", 128'(addr0), 128'h19);
        chk("first_idx", 128'(idx0), 128'(0));
        nb = 1; lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (busy0) nb++;
            if (done0) begin lat = n; break; end
        end
        chk("t1_latency", 128'(lat), 128'(17));
        chk("t1_busy_cycles", 128'(nb), 128'(17));
        chk("t1_result", out0, V1_F);
        repeat (3) tick();

        // Inverse instance with identity S-box
        run_pass(V1_F, 0, 0, 1'b0, lat, nb);
        chk("t3_latency", 128'(lat), 128'(17));
        chk("t3_result_inv", out1, V3_I);
        chk("t3_result_fwd", out0, shift_model({sb(V1_F[127:120]), sb(V1_F[119:112]),
            sb(V1_F[111:104]), sb(V1_F[103:96]), sb(V1_F[95:88]), sb(V1_F[87:80]),
            sb(V1_F[79:72]), sb(V1_F[71:64]), sb(V1_F[63:56]), sb(V1_F[55:48]),
            sb(V1_F[47:40]), sb(V1_F[39:32]), sb(V1_F[31:24]), sb(V1_F[23:16]),
            sb(V1_F[15:8]), sb(V1_F[7:0])}, 1'b0));

        // Back-to-back: second start lands in the done cycle
        run_pass(V1, 0, 0, 1'b0, lat, nb);
        chk("t4a_latency", 128'(lat), 128'(17));
        run_pass(V4, 0, 0, 1'b0, lat, nb);
        chk("t4b_latency", 128'(lat), 128'(17));
        tick();
        chk("t4_done_dropped", 128'(done0), 128'(0));
        repeat (2) tick();

        // start pokes and state_in churn while busy
        run_pass(V1, 3, 16, 1'b1, lat, nb);
        chk("t5_latency", 128'(lat), 128'(17));
        chk("t5_result", out0, V1_F);
        state_in = '0;
        repeat (25) tick();
        chk("t5_no_extra_busy", 128'(busy0), 128'(0));

        // Reset in SUB cycle 7
        state_in = V4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("t6_pre_idx", 128'(idx0), 128'(6));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", 128'(busy0), 128'(0));
        chk("t6_idx", 128'(idx0), 128'(0));
        chk("t6_out", out0, 128'(0));
        chk("t6_done", 128'(done0), 128'(0));
        repeat (20) tick();
        run_pass(V1, 0, 0, 1'b0, lat, nb);
        chk("t6_latency", 128'(lat), 128'(17));
        chk("t6_result", out0, V1_F);
        repeat (3) tick();

        chk("done_count0", 128'(ndone0), 128'(6));
        chk("done_count1", 128'(ndone1), 128'(6));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
